// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo buffer slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } tx_state_e;

  typedef enum logic [1:0] {
    CASE_PASS  = 2'd0,
    CASE_UPPER = 2'd1,
    CASE_LOWER = 2'd2
  } case_mode_e;

  localparam logic [7:0] ASCII_UC_A       = 8'h41;
  localparam logic [7:0] ASCII_UC_Z       = 8'h5A;
  localparam logic [7:0] ASCII_LC_A       = 8'h61;
  localparam logic [7:0] ASCII_LC_Z       = 8'h7A;
  localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

  // Map a letter to the requested case; every other byte is returned unchanged.
  function automatic logic [7:0] case_convert(input logic [7:0] b, input case_mode_e mode);
    logic [7:0] r;
    r = b;
    if (mode == CASE_UPPER && b >= ASCII_LC_A && b <= ASCII_LC_Z) begin
      r = b - ASCII_CASE_DELTA;
    end else if (mode == CASE_LOWER && b >= ASCII_UC_A && b <= ASCII_UC_Z) begin
      r = b + ASCII_CASE_DELTA;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered read, occupancy counter and flush.
// Pop on empty is ignored; push on full succeeds only alongside a pop.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned LEVEL_W = ADDR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LEVEL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && !flush && (!full || do_pop);

  // Pointer and occupancy bookkeeping; flush empties the buffer on the next edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Registered read port; a pop accepted alongside a flush still delivers its entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (do_pop) begin
      rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// UART echo buffer: converts and queues received payloads, replays them to uart_tx.
// Optional statistics outputs are enabled by defining UART_ECHO_BUFFER_STATS_EN.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CASE_MODE    = 0,
  parameter int unsigned BUSY_WAIT    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [PAYLOAD_BITS-1:0]         rx_data,
  input  logic                            rx_valid,
  input  logic                            rx_break,
  output logic [PAYLOAD_BITS-1:0]         tx_data,
  output logic                            tx_en,
  input  logic                            tx_busy,
  output logic [PAYLOAD_BITS-1:0]         led,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            fifo_full,
  output logic                            fifo_empty,
  output logic                            overflow,
  input  logic                            clear_overflow
`ifdef UART_ECHO_BUFFER_STATS_EN
  ,
  output logic [31:0]                     rx_count,
  output logic [15:0]                     drop_count
`endif
);

  localparam case_mode_e EFF_MODE =
    (PAYLOAD_BITS != 8) ? CASE_PASS  :
    (CASE_MODE == 1)    ? CASE_UPPER :
    (CASE_MODE == 2)    ? CASE_LOWER : CASE_PASS;
  localparam int unsigned WAIT_W    = (BUSY_WAIT < 1) ? 1 : $clog2(BUSY_WAIT + 1);
  localparam int unsigned WAIT_LAST = (BUSY_WAIT > 0) ? BUSY_WAIT - 1 : 0;

  tx_state_e               state;
  tx_state_e               state_next;
  logic [PAYLOAD_BITS-1:0] conv_data;
  logic [PAYLOAD_BITS-1:0] fifo_rd_data;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    pop;
  logic                    load_tx;
  logic                    push_req;
  logic                    drop;

  if (PAYLOAD_BITS == 8) begin : g_ascii
    assign conv_data = case_convert(rx_data, EFF_MODE);
  end else begin : g_raw
    assign conv_data = rx_data;
  end

  // A break discards the push silently; only a full buffer with no pop counts as a drop.
  assign push_req = rx_valid && !rx_break;
  assign drop     = push_req && fifo_full && !pop;

  uart_sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (rx_break),
    .wr_en   (push_req),
    .wr_data (conv_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // TX FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // TX FSM next-state and strobes.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_tx    = 1'b0;
    tx_en      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        load_tx    = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        tx_en      = 1'b1;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy || wait_cnt == WAIT_W'(WAIT_LAST)) state_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Cycles spent in WAIT_HI, bounding how long we wait for tx_busy to rise.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT_HI) wait_cnt <= '0;
    else if (wait_cnt != '1)       wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Transmit data holding register, updated only in LOAD.
  always_ff @(posedge clk) begin
    if (reset)        tx_data <= '0;
    else if (load_tx) tx_data <= fifo_rd_data;
  end

  // Display register and sticky overflow (a new drop beats a clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      led      <= '0;
      overflow <= 1'b0;
    end else begin
      if (rx_valid)            led      <= conv_data;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

`ifdef UART_ECHO_BUFFER_STATS_EN
  // Saturating accepted-push and discard counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (push_req && !drop && rx_count != '1)
        rx_count <= rx_count + 32'd1;
      if ((drop || (rx_valid && rx_break)) && drop_count != '1)
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench: three instances (pass, upper, lower) share one stimulus stream.
module tb_uart_echo_buffer;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned LW = 3;

  logic         clk = 1'b0;
  logic         reset, rx_valid, rx_break, tx_busy, clear_overflow;
  logic [W-1:0] rx_data;

  logic [W-1:0]  tx_data [3];
  logic          tx_en   [3];
  logic [W-1:0]  led     [3];
  logic [LW-1:0] level   [3];
  logic          full    [3];
  logic          empty   [3];
  logic          ovf     [3];
`ifdef UART_ECHO_BUFFER_STATS_EN
  logic [31:0]   rx_count   [3];
  logic [15:0]   drop_count [3];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_echo_buffer #(
      .PAYLOAD_BITS (W),
      .FIFO_DEPTH   (D),
      .CASE_MODE    (g),
      .BUSY_WAIT    (2)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_break       (rx_break),
      .tx_data        (tx_data[g]),
      .tx_en          (tx_en[g]),
      .tx_busy        (tx_busy),
      .led            (led[g]),
      .fifo_level     (level[g]),
      .fifo_full      (full[g]),
      .fifo_empty     (empty[g]),
      .overflow       (ovf[g]),
      .clear_overflow (clear_overflow)
`ifdef UART_ECHO_BUFFER_STATS_EN
      ,
      .rx_count       (rx_count[g]),
      .drop_count     (drop_count[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_tx_en",   32'(tx_en[0]),   32'd0);
    chk("rst_tx_data", 32'(tx_data[0]), 32'h0);
    chk("rst_led",     32'(led[0]),     32'h0);
    chk("rst_level",   32'(level[0]),   32'd0);
    chk("rst_empty",   32'(empty[0]),   32'd1);
    chk("rst_full",    32'(full[0]),    32'd0);
    chk("rst_ovf",     32'(ovf[0]),     32'd0);
`ifdef UART_ECHO_BUFFER_STATS_EN
    chk("rst_rx_count",   rx_count[0],          32'd0);
    chk("rst_drop_count", 32'(drop_count[0]),   32'd0);
`endif
  endtask

  // Emulates uart_tx accepting the frame: busy rises, holds, then falls.
  task automatic busy_cycle();
    tx_busy = 1'b1;
    tick();
    chk("tx_en_one_cycle", 32'(tx_en[0]), 32'd0);
    tick();
    tick();
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic wait_tx(input logic [W-1:0] exp);
    for (int i = 0; i < 20 && !tx_en[0]; i++) tick();
    chk("tx_en_seen", 32'(tx_en[0]), 32'd1);
    chk("tx_order",   32'(tx_data[0]), 32'(exp));
  endtask

  // Idle, empty FIFO: tx_en must be high in the cycle after the second edge past the push.
  task automatic echo_latency(input logic [W-1:0] d, input logic [W-1:0] e0,
                              input logic [W-1:0] e1, input logic [W-1:0] e2);
    push(d);
    chk("led_pass",  32'(led[0]), 32'(e0));
    chk("led_upper", 32'(led[1]), 32'(e1));
    chk("led_lower", 32'(led[2]), 32'(e2));
    chk("lat_push",  32'(tx_en[0]), 32'd0);
    tick();
    chk("lat_load",  32'(tx_en[0]), 32'd0);
    tick();
    chk("lat_issue", 32'(tx_en[0]), 32'd1);
    chk("tx_pass",   32'(tx_data[0]), 32'(e0));
    chk("tx_upper",  32'(tx_data[1]), 32'(e1));
    chk("tx_lower",  32'(tx_data[2]), 32'(e2));
    busy_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [W-1:0] order [5];
    reset = 1'b1; rx_valid = 1'b0; rx_break = 1'b0; tx_busy = 1'b0;
    clear_overflow = 1'b0; rx_data = '0;
    tick();
    tick();
    check_reset_vals();
    reset = 1'b0;
    tick();

    // Single echoes and case conversion across the three modes.
    echo_latency(8'h5A, 8'h5A, 8'h5A, 8'h7A);
    echo_latency(8'h61, 8'h61, 8'h41, 8'h61);
    echo_latency(8'h7B, 8'h7B, 8'h7B, 8'h7B);
    echo_latency(8'h41, 8'h41, 8'h41, 8'h61);

    // Burst into a busy transmitter until full, then overflow handling.
    tx_busy = 1'b1;
    for (int i = 1; i <= 4; i++) push(8'(i));
    chk("burst_full",  32'(full[0]),  32'd1);
    chk("burst_level", 32'(level[0]), 32'd4);
    chk("burst_ovf",   32'(ovf[0]),   32'd0);
    push(8'h05);
    chk("drop_ovf",   32'(ovf[0]),   32'd1);
    chk("drop_led",   32'(led[0]),   32'h05);
    chk("drop_level", 32'(level[0]), 32'd4);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clear_ovf", 32'(ovf[0]), 32'd0);
    clear_overflow = 1'b1;
    push(8'h06);
    clear_overflow = 1'b0;
    chk("set_beats_clear", 32'(ovf[0]), 32'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clear_ovf2", 32'(ovf[0]), 32'd0);

    // Release busy with a push on the same edge as the first pop while full.
    tx_busy = 1'b0;
    push(8'h07);
    chk("full_pushpop_level", 32'(level[0]), 32'd4);
    chk("full_pushpop_ovf",   32'(ovf[0]),   32'd0);
    order[0] = 8'h01; order[1] = 8'h02; order[2] = 8'h03;
    order[3] = 8'h04; order[4] = 8'h07;
    for (int i = 0; i < 5; i++) begin
      wait_tx(order[i]);
      busy_cycle();
    end
    chk("drained_empty", 32'(empty[0]), 32'd1);

    // Break flush with a simultaneous push while a byte is in flight.
    tx_busy = 1'b1;
    push(8'h11);
    push(8'h12);
    push(8'h13);
    chk("brk_level3", 32'(level[0]), 32'd3);
    tx_busy = 1'b0;
    wait_tx(8'h11);
    chk("brk_level2", 32'(level[0]), 32'd2);
    rx_break = 1'b1;
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    tx_busy  = 1'b1;
    tick();
    rx_break = 1'b0;
    rx_valid = 1'b0;
    chk("brk_level0", 32'(level[0]), 32'd0);
    chk("brk_empty",  32'(empty[0]), 32'd1);
    chk("brk_ovf",    32'(ovf[0]),   32'd0);
    tick();
    tick();
    tx_busy = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_en[0]) pulses++;
    end
    chk("brk_no_more_tx", 32'(pulses),     32'd0);
    chk("brk_tx_hold",    32'(tx_data[0]), 32'h11);

    // Reset while waiting for tx_busy to fall.
    push(8'h33);
    wait_tx(8'h33);
    tx_busy = 1'b1;
    tick();
    tick();
    push(8'h44);
    chk("wlo_level", 32'(level[0]), 32'd1);
`ifdef UART_ECHO_BUFFER_STATS_EN
    chk("stat_rx_count",   rx_count[0],        32'd14);
    chk("stat_drop_count", 32'(drop_count[0]), 32'd3);
`endif
    reset = 1'b1;
    tick();
    check_reset_vals();
    reset   = 1'b0;
    tx_busy = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tx_en[0]) pulses++;
    end
    chk("post_reset_quiet", 32'(pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_buffer.md
Name: uart_echo_buffer

Overview:
- Parametrised successor to the single-byte UART loopback glue.
- Sits between a uart_rx instance and a uart_tx instance and echoes received payloads back out.
- Buffers received payloads in a FIFO so that back-to-back RX bursts are not lost while TX is busy.
- Adds an optional ASCII case-conversion mode, a last-byte display register, an overflow flag and a break-flush feature.

Parameters:
- PAYLOAD_BITS, 8: payload width in bits.
- FIFO_DEPTH, 16: buffer entries; must be a power of 2 and at least 2.
- CASE_MODE, 0: 0 = pass through, 1 = force upper case, 2 = force lower case. Modes 1 and 2 apply only when PAYLOAD_BITS == 8; otherwise the block behaves as mode 0.
- BUSY_WAIT, 2: maximum cycles to wait for tx_busy to rise after issuing tx_en.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- rx_data, in, PAYLOAD_BITS: received payload from uart_rx.
- rx_valid, in, 1: one-cycle strobe; rx_data is valid.
- rx_break, in, 1: BREAK detected by uart_rx.
- tx_data, out, PAYLOAD_BITS: payload to uart_tx.
- tx_en, out, 1: one-cycle transmit request.
- tx_busy, in, 1: uart_tx is transmitting.
- led, out, PAYLOAD_BITS: last accepted payload, after conversion.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: current occupancy.
- fifo_full, out, 1: occupancy == FIFO_DEPTH.
- fifo_empty, out, 1: occupancy == 0.
- overflow, out, 1: sticky flag; a payload was dropped.
- clear_overflow, in, 1: clears overflow.

Behaviour:
- Reset (synchronous, active-high):
  - tx_en=0, tx_data=0, led=0, fifo_level=0, fifo_empty=1, fifo_full=0, overflow=0.
  - FSM goes to IDLE; read and write pointers go to 0.
  - Reset asserted mid-transmission abandons the FSM state only; the uart_tx frame already in progress is not affected.
- Conversion (combinational, before the FIFO write):
  - Mode 1: bytes 0x61..0x7A have 0x20 subtracted.
  - Mode 2: bytes 0x41..0x5A have 0x20 added.
  - All other bytes are unchanged.
- Push: on rx_valid=1, the converted payload is written and led is updated on the same edge.
- Full with rx_valid and no pop in the same cycle: payload dropped, overflow set to 1, led still updated.
- Pop and push in the same cycle while full: both occur and fifo_level is unchanged.
- Pop and push in the same cycle while empty: push only. There is no fall-through; the payload appears at the read side no earlier than the next cycle.
- Pointers are ADDR_W bits wide and wrap modulo FIFO_DEPTH. Occupancy is tracked by a separate counter.
- overflow: clear_overflow=1 clears it. If clear_overflow and a new drop occur in the same cycle, set wins.
- rx_break=1:
  - Flushes the FIFO: pointers and level go to 0 on the next edge.
  - Takes priority over a simultaneous push; that push is discarded without setting overflow.
  - The FSM is not affected if it is past LOAD.
- TX FSM:
  - IDLE: if !fifo_empty && !tx_busy -> LOAD and assert the memory read (pop).
  - LOAD: registered read data arrives -> tx_data latched -> ISSUE.
  - ISSUE: tx_en=1 for exactly one cycle -> WAIT_HI.
  - WAIT_HI: if tx_busy=1, or BUSY_WAIT cycles elapse -> WAIT_LO.
  - WAIT_LO: if tx_busy=0 -> IDLE.
- Latency: first rx_valid into an empty FIFO with TX idle gives tx_en 3 cycles after the rx_valid edge (push, IDLE->LOAD, LOAD->ISSUE).
- tx_data is held stable from ISSUE until the next LOAD.

Optional Feature:
- Macro: UART_ECHO_BUFFER_STATS_EN.
- When defined, adds two outputs:
  - rx_count (32 bits): accepted pushes.
  - drop_count (16 bits): dropped payloads, counting both overflow and break discards.
  - Both counters saturate at all-ones and reset to 0.
- When undefined, neither the ports nor the counters exist, and all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum: IDLE, LOAD, ISSUE, WAIT_HI, WAIT_LO.
  - CASE_MODE encodings: CASE_PASS, CASE_UPPER, CASE_LOWER.
  - ASCII constants 0x41, 0x5A, 0x61, 0x7A, 0x20.
- One sub-module: uart_sync_fifo. It has a registered read, exposes level/full/empty and a flush input, and is parametrised by WIDTH and DEPTH.

Test Plan:
- Single echo, mode 0: rx 0x5A while idle -> tx_en pulse 3 cycles later with tx_data=0x5A; led=0x5A.
- Burst, DEPTH=4: push 0x01..0x04 back-to-back with tx_busy held high -> fifo_full=1, overflow=0. Release busy -> transmitted in order 0x01, 0x02, 0x03, 0x04, one tx_en per busy low-high-low cycle.
- Overflow: push a 5th byte 0x05 while full and busy -> dropped, overflow=1, led=0x05. clear_overflow -> overflow=0. Simultaneous clear and drop -> overflow=1.
- Case mode 1: rx 0x61, 0x7B, 0x41 -> tx 0x41, 0x7B, 0x41. Mode 2: rx 0x5A -> tx 0x7A.
- Break flush: 3 entries queued, then rx_break with a simultaneous rx_valid -> fifo_level=0 next cycle; the in-flight byte still completes; no overflow.
- Reset mid-WAIT_LO -> all outputs at reset values next cycle. With STATS_EN defined: rx_count=0 and drop_count=0.
